// File: rtl/hamming_router_pkg.sv
// Shared Hamming(7,4) / SECDED encoding helpers and codeword sizing for the
// channel router.
package hamming_router_pkg;

  // Codeword bit order c[6:0] = {d3, d2, d1, p3, d0, p1, p0}.
  function automatic logic [6:0] hamming74_enc(input logic [3:0] d);
    return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3],
            d[0] ^ d[1] ^ d[3]};
  endfunction

  function automatic logic secded_bit(input logic [6:0] c);
    return ^c;
  endfunction

  function automatic int cw_width(input int nib, input int secded);
    return nib * (7 + secded);
  endfunction

endpackage

// File: rtl/hamming_router_q_fifo.sv
// Per-channel codeword FIFO: head is read straight from storage at the read
// pointer, and full/empty are resolved with one extra wrap bit per pointer.
module chan_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign dout  = r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push && !full) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop && !empty) r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are live, so a reset keeps the RAM cheap and still discards data.
  always_ff @(posedge clk) begin
    if (push && !full) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/hamming_router_q.sv
// Hamming-encodes a multi-nibble payload and queues it to one of N_CH
// independent output channels; invalid destinations are dropped and counted.
module hamming_router_q
  import hamming_router_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int ADDR_W = 2,
  parameter int NIB    = 1,
  parameter int SECDED = 0,
  parameter int DEPTH  = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [ADDR_W-1:0]                     in_dest,
  input  logic [4*NIB-1:0]                      in_data,
  output logic [N_CH-1:0]                       out_valid,
  input  logic [N_CH-1:0]                       out_ready,
  output logic [N_CH*cw_width(NIB, SECDED)-1:0] out_data,
  output logic [7:0]                            drop_cnt
);
  localparam int CWN = 7 + SECDED;
  localparam int CW  = cw_width(NIB, SECDED);

  logic [CW-1:0]   w_cw;
  logic [CW-1:0]   w_head [N_CH];
  logic [N_CH-1:0] w_full;
  logic [N_CH-1:0] w_empty;
  logic [N_CH-1:0] w_push;
  logic [N_CH-1:0] w_pop;
  logic            w_dest_ok;
  logic            w_dest_full;
  logic            w_accept;
  logic [7:0]      r_drop_cnt;

  for (genvar k = 0; k < NIB; k++) begin : g_enc
    logic [6:0] w_enc;
    assign w_enc = hamming74_enc(in_data[4*k +: 4]);
    if (SECDED != 0) begin : g_secded
      assign w_cw[k*CWN +: CWN] = {secded_bit(w_enc), w_enc};
    end else begin : g_plain
      assign w_cw[k*CWN +: CWN] = w_enc;
    end
  end

  assign w_dest_ok = (32'(in_dest) < N_CH);

  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    w_dest_full = 1'b0;
    for (int j = 0; j < N_CH; j++) begin
      if (in_dest == ADDR_W'(j)) w_dest_full = w_full[j];
    end
  end

  // Ready depends only on registered FIFO state, never on out_ready.
  assign in_ready = !rst && !(w_dest_ok && w_dest_full);
  assign w_accept = in_valid && in_ready;

  for (genvar j = 0; j < N_CH; j++) begin : g_ch
    assign w_push[j] = w_accept && w_dest_ok && (in_dest == ADDR_W'(j));
    assign w_pop[j]  = !w_empty[j] && out_ready[j];

    chan_fifo #(.WIDTH(CW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push[j]),
      .din   (w_cw),
      .pop   (w_pop[j]),
      .dout  (w_head[j]),
      .full  (w_full[j]),
      .empty (w_empty[j])
    );

    assign out_valid[j]           = !w_empty[j];
    assign out_data[j*CW +: CW]   = out_valid[j] ? w_head[j] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_accept && !w_dest_ok && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_hamming_router_q.sv
// Self-checking bench: directed scenarios on three configurations plus a
// randomized run against a queue-based reference model.
module tb_hamming_router_q;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // A: defaults (4 ch, NIB=1, SECDED=0, DEPTH=4)
  logic        a_in_valid = 1'b0, a_in_ready;
  logic [1:0]  a_in_dest = '0;
  logic [3:0]  a_in_data = '0;
  logic [3:0]  a_out_valid, a_out_ready = '0;
  logic [27:0] a_out_data;
  logic [7:0]  a_drop_cnt;
  // B: 2 ch, NIB=2, SECDED=1
  logic        b_in_valid = 1'b0, b_in_ready;
  logic [0:0]  b_in_dest = '0;
  logic [7:0]  b_in_data = '0;
  logic [1:0]  b_out_valid, b_out_ready = '0;
  logic [31:0] b_out_data;
  logic [7:0]  b_drop_cnt;
  // C: 3 ch on a 2-bit address, DEPTH=2
  logic        c_in_valid = 1'b0, c_in_ready;
  logic [1:0]  c_in_dest = '0;
  logic [3:0]  c_in_data = '0;
  logic [2:0]  c_out_valid, c_out_ready = '0;
  logic [20:0] c_out_data;
  logic [7:0]  c_drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [6:0] qa [4][$];
  logic [6:0] qc [3][$];

  hamming_router_q u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_dest(a_in_dest), .in_data(a_in_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .drop_cnt(a_drop_cnt));

  hamming_router_q #(.N_CH(2), .ADDR_W(1), .NIB(2), .SECDED(1), .DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_dest(b_in_dest), .in_data(b_in_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .drop_cnt(b_drop_cnt));

  hamming_router_q #(.N_CH(3), .ADDR_W(2), .NIB(1), .SECDED(0), .DEPTH(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_dest(c_in_dest), .in_data(c_in_data), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_data(c_out_data), .drop_cnt(c_drop_cnt));

  // Classic positional Hamming construction: data at positions 3,5,6,7,
  // parity at power-of-two positions covering every position sharing that bit.
  function automatic logic [6:0] ref_enc(input logic [3:0] d);
    logic [7:1] w;
    w = '0;
    w[3] = d[0]; w[5] = d[1]; w[6] = d[2]; w[7] = d[3];
    for (int p = 1; p <= 4; p = p * 2)
      for (int pos = 3; pos <= 7; pos++)
        if ((pos & p) != 0 && pos != p) w[p] = w[p] ^ w[pos];
    return w;
  endfunction

  task automatic test_reset();
    a_in_valid = 1'b1; a_in_dest = 2'd0;
    c_in_valid = 1'b1; c_in_dest = 2'd3;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", a_in_ready); end
    checks++; if (c_in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_drop got %b exp 0", c_in_ready); end
    checks++; if (a_out_valid !== 4'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", a_out_valid); end
    checks++; if (a_out_data !== 28'b0) begin errors++; $display("FAIL reset_data got %h exp 0", a_out_data); end
    checks++; if (c_drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", c_drop_cnt); end
    @(negedge clk);
    rst = 1'b0; a_in_valid = 1'b0; c_in_valid = 1'b0;
  endtask

  task automatic test_single();
    logic [27:0] exp_d;
    @(negedge clk);
    a_in_valid = 1'b1; a_in_dest = 2'd2; a_in_data = 4'b1011;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", a_in_ready); end
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    exp_d = '0; exp_d[20:14] = 7'h55;
    checks++; if (a_out_valid !== 4'b0100) begin errors++; $display("FAIL single_valid got %b exp 0100", a_out_valid); end
    checks++; if (a_out_data !== exp_d) begin errors++; $display("FAIL single_data got %h exp %h", a_out_data, exp_d); end
    a_out_ready = 4'b0100;
    @(negedge clk);
    a_out_ready = 4'b0;
    #1;
    checks++; if (a_out_valid !== 4'b0 || a_out_data !== 28'b0) begin errors++; $display("FAIL single_drain got %b/%h exp 0/0", a_out_valid, a_out_data); end
  endtask

  task automatic test_secded();
    @(negedge clk);
    b_in_valid = 1'b1; b_in_dest = 1'b0; b_in_data = 8'h11;
    #1;
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL secded_ready got %b exp 1", b_in_ready); end
    @(negedge clk);
    b_in_valid = 1'b0;
    #1;
    checks++; if (b_out_valid !== 2'b01) begin errors++; $display("FAIL secded_valid got %b exp 01", b_out_valid); end
    checks++; if (b_out_data !== 32'h0000_8787) begin errors++; $display("FAIL secded_data got %h exp 00008787", b_out_data); end
    checks++; if (b_drop_cnt !== 8'd0) begin errors++; $display("FAIL secded_drop got %0d exp 0", b_drop_cnt); end
    b_out_ready = 2'b01;
    @(negedge clk);
    b_out_ready = 2'b00;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_in_valid = 1'b1; a_in_dest = 2'd1; a_in_data = 4'(i);
      #1;
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got %b exp 1", i, a_in_ready); end
    end
    @(negedge clk);
    a_in_dest = 2'd1; a_in_data = 4'hE;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL fill_full got %b exp 0", a_in_ready); end
    a_in_dest = 2'd3; a_in_data = 4'hA;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL fill_other got %b exp 1", a_in_ready); end
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    checks++; if (a_out_valid !== 4'b1010) begin errors++; $display("FAIL fill_valid got %b exp 1010", a_out_valid); end
    checks++; if (a_out_data[27:21] !== ref_enc(4'hA)) begin errors++; $display("FAIL fill_slot3 got %h exp %h", a_out_data[27:21], ref_enc(4'hA)); end
    checks++; if (a_out_data[13:7] !== ref_enc(4'h0)) begin errors++; $display("FAIL fill_slot1 got %h exp %h", a_out_data[13:7], ref_enc(4'h0)); end
    a_out_ready = 4'b1000;
    @(negedge clk);
    a_out_ready = 4'b0;
    #1;
    checks++; if (a_out_valid !== 4'b0010) begin errors++; $display("FAIL fill_drain3 got %b exp 0010", a_out_valid); end
  endtask

  task automatic test_full_pop();
    @(negedge clk);
    a_in_valid = 1'b1; a_in_dest = 2'd1; a_in_data = 4'hF; a_out_ready = 4'b0010;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL fullpop_refuse got %b exp 0", a_in_ready); end
    @(negedge clk);
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL fullpop_ready got %b exp 1", a_in_ready); end
    a_in_valid = 1'b0;
    checks++; if (a_out_data[13:7] !== ref_enc(4'd1)) begin errors++; $display("FAIL fullpop_order_1 got %h exp %h", a_out_data[13:7], ref_enc(4'd1)); end
    for (int i = 2; i < 4; i++) begin
      @(negedge clk);
      #1;
      checks++; if (a_out_data[13:7] !== ref_enc(4'(i))) begin errors++; $display("FAIL fullpop_order_%0d got %h exp %h", i, a_out_data[13:7], ref_enc(4'(i))); end
    end
    @(negedge clk);
    a_out_ready = 4'b0;
    #1;
    checks++; if (a_out_valid !== 4'b0) begin errors++; $display("FAIL fullpop_empty got %b exp 0", a_out_valid); end
  endtask

  task automatic test_drop();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      c_in_valid = 1'b1; c_in_dest = 2'd3; c_in_data = 4'($urandom);
      #1;
      checks++; if (c_in_ready !== 1'b1) begin errors++; $display("FAIL drop_ready_%0d got %b exp 1", i, c_in_ready); end
      checks++; if (c_out_valid !== 3'b0) begin errors++; $display("FAIL drop_valid_%0d got %b exp 0", i, c_out_valid); end
      checks++; if (c_drop_cnt !== 8'((i > 255) ? 255 : i)) begin errors++; $display("FAIL drop_cnt_%0d got %0d exp %0d", i, c_drop_cnt, (i > 255) ? 255 : i); end
    end
    @(negedge clk);
    c_in_valid = 1'b0;
    #1;
    checks++; if (c_drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_sat got %0d exp 255", c_drop_cnt); end
  endtask

  task automatic test_reset_mid();
    for (int i = 3; i < 5; i++) begin
      @(negedge clk);
      a_in_valid = 1'b1; a_in_dest = 2'd0; a_in_data = 4'(i);
    end
    @(negedge clk);
    #1;
    checks++; if (a_out_valid !== 4'b0001) begin errors++; $display("FAIL rmid_pre got %b exp 0001", a_out_valid); end
    rst = 1'b1;
    #1;
    checks++; if (a_out_valid !== 4'b0 || a_out_data !== 28'b0) begin errors++; $display("FAIL rmid_clear got %b/%h exp 0/0", a_out_valid, a_out_data); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready got %b exp 0", a_in_ready); end
    @(negedge clk);
    rst = 1'b0; a_in_data = 4'd5;
    #1;
    checks++; if (c_drop_cnt !== 8'd0) begin errors++; $display("FAIL rmid_drop got %0d exp 0", c_drop_cnt); end
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    checks++; if (a_out_valid !== 4'b0001 || a_out_data[6:0] !== ref_enc(4'd5)) begin errors++; $display("FAIL rmid_next got %b/%h exp 0001/%h", a_out_valid, a_out_data[6:0], ref_enc(4'd5)); end
    a_out_ready = 4'b0001;
    @(negedge clk);
    a_out_ready = 4'b0;
    #1;
    checks++; if (a_out_valid !== 4'b0) begin errors++; $display("FAIL rmid_discard got %b exp 0", a_out_valid); end
  endtask

  task automatic test_random();
    logic [27:0] ea_d;
    logic [20:0] ec_d;
    logic [3:0]  ea_v;
    logic [2:0]  ec_v;
    logic        ea_r, ec_r;
    int          drop_m = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      a_in_valid = ($urandom_range(0, 3) != 0); a_in_dest = 2'($urandom);
      a_in_data = 4'($urandom); a_out_ready = 4'($urandom);
      c_in_valid = ($urandom_range(0, 3) != 0); c_in_dest = 2'($urandom);
      c_in_data = 4'($urandom); c_out_ready = 3'($urandom);
      #1;
      ea_d = '0; ea_v = '0; ec_d = '0; ec_v = '0;
      for (int j = 0; j < 4; j++)
        if (qa[j].size() != 0) begin ea_v[j] = 1'b1; ea_d[j*7 +: 7] = qa[j][0]; end
      for (int j = 0; j < 3; j++)
        if (qc[j].size() != 0) begin ec_v[j] = 1'b1; ec_d[j*7 +: 7] = qc[j][0]; end
      ea_r = (qa[a_in_dest].size() < 4);
      ec_r = (c_in_dest == 2'd3) ? 1'b1 : (qc[c_in_dest].size() < 2);
      checks++; if (a_out_valid !== ea_v) begin errors++; $display("FAIL rand_a_valid@%0d got %b exp %b", n, a_out_valid, ea_v); end
      checks++; if (a_out_data !== ea_d) begin errors++; $display("FAIL rand_a_data@%0d got %h exp %h", n, a_out_data, ea_d); end
      checks++; if (a_in_ready !== ea_r) begin errors++; $display("FAIL rand_a_ready@%0d got %b exp %b", n, a_in_ready, ea_r); end
      checks++; if (c_out_valid !== ec_v) begin errors++; $display("FAIL rand_c_valid@%0d got %b exp %b", n, c_out_valid, ec_v); end
      checks++; if (c_out_data !== ec_d) begin errors++; $display("FAIL rand_c_data@%0d got %h exp %h", n, c_out_data, ec_d); end
      checks++; if (c_in_ready !== ec_r) begin errors++; $display("FAIL rand_c_ready@%0d got %b exp %b", n, c_in_ready, ec_r); end
      checks++; if (c_drop_cnt !== 8'(drop_m)) begin errors++; $display("FAIL rand_c_drop@%0d got %0d exp %0d", n, c_drop_cnt, drop_m); end
      for (int j = 0; j < 4; j++) if (ea_v[j] && a_out_ready[j]) void'(qa[j].pop_front());
      for (int j = 0; j < 3; j++) if (ec_v[j] && c_out_ready[j]) void'(qc[j].pop_front());
      if (a_in_valid && ea_r) qa[a_in_dest].push_back(ref_enc(a_in_data));
      if (c_in_valid && ec_r) begin
        if (c_in_dest == 2'd3) drop_m = (drop_m < 255) ? drop_m + 1 : 255;
        else qc[c_in_dest].push_back(ref_enc(c_in_data));
      end
    end
    @(negedge clk);
    a_in_valid = 1'b0; c_in_valid = 1'b0; a_out_ready = '0; c_out_ready = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_secded();
    test_fill();
    test_full_pop();
    test_drop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
